// File: rtl/result_display.sv
// Purpose : BCD conversion (sequential double-dabble) and 4-digit multiplexed seven-segment drive for the calculator result.
// Ports   : clk/rst (sync, active-high); value/err/load from arithmetic stage; busy/done status; an/seg/dp display outputs.
// Timing  : load sampled at edge N, display updates and done pulses at edge N+9; load ignored while busy (no queueing).
module result_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       err,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    state_t                  state_q, state_d;
    logic [7:0]              sr_q, sr_d;
    logic [11:0]             bcd_q, bcd_d;
    logic [2:0]              step_q, step_d;
    logic                    err_l_q, err_l_d;
    logic [3:0]              hun_q, hun_d;
    logic [3:0]              ten_q, ten_d;
    logic [3:0]              one_q, one_d;
    logic                    err_disp_q, err_disp_d;
    logic                    done_q, done_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // State register plus all datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            err_l_q    <= 1'b0;
            hun_q      <= '0;
            ten_q      <= '0;
            one_q      <= '0;
            err_disp_q <= 1'b0;
            done_q     <= 1'b0;
            refresh_q  <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bcd_q      <= bcd_d;
            step_q     <= step_d;
            err_l_q    <= err_l_d;
            hun_q      <= hun_d;
            ten_q      <= ten_d;
            one_q      <= one_d;
            err_disp_q <= err_disp_d;
            done_q     <= done_d;
            refresh_q  <= refresh_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (step_q == 3'd7) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        logic [11:0] adj;
        logic [19:0] shifted;
        sr_d       = sr_q;
        bcd_d      = bcd_q;
        step_d     = step_q;
        err_l_d    = err_l_q;
        hun_d      = hun_q;
        ten_d      = ten_q;
        one_d      = one_q;
        err_disp_d = err_disp_q;
        done_d     = (state_q == COMMIT);
        refresh_d  = refresh_q + REFRESH_BITS'(1);
        adj        = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        shifted    = {adj, sr_q} << 1;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sr_d    = value;
                    err_l_d = err;
                    bcd_d   = '0;
                    step_d  = '0;
                end
            end
            SHIFT: begin
                bcd_d  = shifted[19:8];
                sr_d   = shifted[7:0];
                step_d = step_q + 3'd1;
            end
            COMMIT: begin
                hun_d      = bcd_q[11:8];
                ten_d      = bcd_q[7:4];
                one_d      = bcd_q[3:0];
                err_disp_d = err_l_q;
            end
            default: ;
        endcase
    end

    // Outputs: status plus digit multiplexing, all from registered state
    always_comb begin
        logic [1:0] digit_sel;
        digit_sel = refresh_q[REFRESH_BITS-1 -: 2];
        busy      = (state_q != IDLE);
        done      = done_q;
        dp        = 1'b1;
        an        = 4'b1110;
        seg       = SEG_BLANK;
        case (digit_sel)
            2'd0: begin
                an  = 4'b1110;
                seg = err_disp_q ? SEG_R : digit_seg(one_q);
            end
            2'd1: begin
                an  = 4'b1101;
                if (err_disp_q)
                    seg = SEG_R;
                else if (hun_q != 4'd0 || ten_q != 4'd0)
                    seg = digit_seg(ten_q);
            end
            2'd2: begin
                an  = 4'b1011;
                if (err_disp_q)
                    seg = SEG_E;
                else if (hun_q != 4'd0)
                    seg = digit_seg(hun_q);
            end
            default: begin
                an  = 4'b0111;
                seg = SEG_BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value;
    logic       err;
    logic       load;
    logic       busy;
    logic       done;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    result_display #(.REFRESH_BITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .err   (err),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watch 16 cycles (one full scan at REFRESH_BITS=4); expected segments picked by the lit anode.
    task automatic scan(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] exp;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) chk({tag, "_done_low"}, done, 1'b0);
            case (an)
                4'b1110: exp = e0;
                4'b1101: exp = e1;
                4'b1011: exp = e2;
                4'b0111: exp = e3;
                default: begin
                    exp = 7'h7F;
                    chk({tag, "_an_onehot"}, an, 4'b1110);
                end
            endcase
            chk({tag, "_seg"}, seg, exp);
        end
    endtask

    // Issue load at the current negedge, check busy/done for 10 cycles; optionally
    // attempt a second load at cycle +inj_at (should be ignored). Ends in the done cycle.
    task automatic load_and_check(input string tag, input logic [7:0] v, input logic e,
                                  input int inj_at, input logic [7:0] inj_v);
        value = v;
        err   = e;
        load  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            load = 1'b0;
            chk({tag, "_busy"}, busy, (i < 10));
            chk({tag, "_done"}, done, (i == 10));
            if (i == inj_at) begin
                value = inj_v;
                err   = 1'b0;
                load  = 1'b1;
            end
        end
    endtask

    initial begin
        logic [3:0] exp_an;
        rst   = 1'b1;
        value = 8'd0;
        err   = 1'b0;
        load  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dp", dp, 1'b1);
        rst = 1'b0;
        // Refresh counter equals i at sample i; digit = i/4.
        for (int i = 0; i < 16; i++) begin
            case ((i >> 2) & 3)
                0:       exp_an = 4'b1110;
                1:       exp_an = 4'b1101;
                2:       exp_an = 4'b1011;
                default: exp_an = 4'b0111;
            endcase
            chk("rst_an", an, exp_an);
            chk("rst_seg", seg, (exp_an == 4'b1110) ? 7'h40 : 7'h7F);
            @(negedge clk);
        end

        load_and_check("ld255", 8'd255, 1'b0, 0, 8'd0);
        scan("d255", 7'h7F, 7'h24, 7'h12, 7'h12);

        load_and_check("ld7", 8'd7, 1'b0, 0, 8'd0);
        scan("d7", 7'h7F, 7'h7F, 7'h7F, 7'h78);

        load_and_check("ld105", 8'd105, 1'b0, 0, 8'd0);
        scan("d105", 7'h7F, 7'h79, 7'h40, 7'h12);

        load_and_check("lderr", 8'd99, 1'b1, 0, 8'd0);
        scan("derr", 7'h7F, 7'h06, 7'h2F, 7'h2F);

        // Second load at +3 must be ignored
        load_and_check("ld200", 8'd200, 1'b0, 3, 8'd13);
        scan("d200", 7'h7F, 7'h24, 7'h40, 7'h40);

        // Load issued in the done cycle is accepted
        load_and_check("ld9", 8'd9, 1'b0, 0, 8'd0);
        load_and_check("ld13", 8'd13, 1'b0, 0, 8'd0);
        scan("d13", 7'h7F, 7'h7F, 7'h79, 7'h30);

        // Reset mid-conversion
        value = 8'd88;
        err   = 1'b0;
        load  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            load = 1'b0;
            chk("ld88_busy", busy, 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        scan("dabort", 7'h7F, 7'h7F, 7'h7F, 7'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
